// File: rtl/npu_pkg.sv
// Shared line geometry and streamer state encoding.
package npu_pkg;

    localparam int LINE_LEN = 32;
    localparam int PIX_W    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } stream_state_t;

endpackage

// File: rtl/line_buffer.sv
// One line of pixels: synchronous host write, combinational read for the streamer.
module line_buffer #(
    parameter int LINE_LEN = 32,
    parameter int PIX_W    = 8,
    parameter int ADDR_W   = $clog2(LINE_LEN)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [PIX_W-1:0]  i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [PIX_W-1:0]  o_rd_data
);

    // Contents survive reset; only the streamer control is cleared.
    logic [PIX_W-1:0] r_mem [LINE_LEN];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/pixel_line_streamer.sv
// Streams a buffered pixel line downstream with a start pulse, ready/valid
// handshake and a done pulse.
//
// state | meaning
// IDLE  | waiting for go; host may write the line buffer
// START | one-cycle frame-start pulse
// SEND  | presenting buf[idx], advancing on tx_ready
// DONE  | one-cycle done pulse after the last pixel is accepted
module pixel_line_streamer
    import npu_pkg::stream_state_t, npu_pkg::IDLE, npu_pkg::START, npu_pkg::SEND, npu_pkg::DONE;
#(
    parameter int LINE_LEN = npu_pkg::LINE_LEN,
    parameter int PIX_W    = npu_pkg::PIX_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [$clog2(LINE_LEN)-1:0] wr_addr,
    input  logic [PIX_W-1:0]            wr_data,
    input  logic                        go,
    output logic                        start,
    output logic                        tx_valid,
    output logic [PIX_W-1:0]            tx_data,
    input  logic                        tx_ready,
    output logic                        busy,
    output logic                        done
);

    localparam int ADDR_W = $clog2(LINE_LEN);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LINE_LEN - 1);

    stream_state_t     r_state;
    logic [ADDR_W-1:0] r_idx;
    logic              r_start;
    logic              r_tx_valid;
    logic              r_done;
    logic              r_busy;

    logic              w_buf_wr;
    logic [PIX_W-1:0]  w_rd_data;

    // Host writes are dropped during a frame so the streamed line stays stable.
    assign w_buf_wr = wr_en && !r_busy;

    line_buffer #(
        .LINE_LEN (LINE_LEN),
        .PIX_W    (PIX_W),
        .ADDR_W   (ADDR_W)
    ) u_line_buffer (
        .clk       (clk),
        .i_wr_en   (w_buf_wr),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_addr (r_idx),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_start    <= 1'b0;
            r_tx_valid <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (go) begin
                        r_state <= START;
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    r_state    <= SEND;
                    r_idx      <= '0;
                    r_start    <= 1'b0;
                    r_tx_valid <= 1'b1;
                end
                SEND: begin
                    if (tx_ready) begin
                        if (r_idx == LAST_IDX) begin
                            r_state    <= DONE;
                            r_idx      <= '0;
                            r_tx_valid <= 1'b0;
                            r_done     <= 1'b1;
                        end else begin
                            r_idx <= r_idx + ADDR_W'(1);
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state    <= IDLE;
                    r_idx      <= '0;
                    r_start    <= 1'b0;
                    r_tx_valid <= 1'b0;
                    r_done     <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign start    = r_start;
    assign tx_valid = r_tx_valid;
    assign done     = r_done;
    assign busy     = r_busy;
    assign tx_data  = r_tx_valid ? w_rd_data : '0;

endmodule
